// File: rtl/axi_wr_arbiter_if.sv
// AXI4 write-channel bundle with N parallel lanes; lane k of every field sits at slice k.
// The master modport drives AW/W and B ready, the slave modport answers them.
interface axi_wr_arbiter_if #(
   parameter int N      = 1,
   parameter int ASIZE  = 32,
   parameter int DSIZE  = 64,
   parameter int IDSIZE = 4,
   parameter int LSIZE  = 8
);
   logic [N-1:0]        awvalid;
   logic [N-1:0]        awready;
   logic [N*ASIZE-1:0]  awaddr;
   logic [N*LSIZE-1:0]  awlen;
   logic [N*IDSIZE-1:0] awid;
   logic [N-1:0]        wvalid;
   logic [N-1:0]        wready;
   logic [N*DSIZE-1:0]  wdata;
   logic [N-1:0]        wlast;
   logic [N-1:0]        bvalid;
   logic [N-1:0]        bready;
   logic [1:0]          bresp;

   modport master (
      output awvalid, awaddr, awlen, awid, wvalid, wdata, wlast, bready,
      input  awready, wready, bvalid, bresp
   );

   modport slave (
      input  awvalid, awaddr, awlen, awid, wvalid, wdata, wlast, bready,
      output awready, wready, bvalid, bresp
   );
endinterface

// File: rtl/axi_wr_arbiter.sv
// Round-robin AXI4 write arbiter: NUM upstream masters share one downstream slave,
// one whole burst (AW, W beats, B) at a time, grant locked until the B handshake.
module axi_wr_arbiter #(
   parameter int NUM    = 4,
   parameter int ASIZE  = 32,
   parameter int DSIZE  = 64,
   parameter int IDSIZE = 4,
   parameter int LSIZE  = 8
) (
   input  logic              axi_aclk,
   input  logic              axi_rst,
   axi_wr_arbiter_if.slave   s,
   axi_wr_arbiter_if.master  m,
   output logic [NUM-1:0]    grant,
   output logic              busy,
   output logic              len_err
);
   localparam int IW = $clog2(NUM);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_AW   = 2'd1,
      ST_W    = 2'd2,
      ST_B    = 2'd3
   } state_t;

   state_t         state_r;
   state_t         state_nxt;
   logic [NUM-1:0] grant_r;
   logic [IW-1:0]  gidx_r;
   logic [IW-1:0]  rr_ptr_r;
   logic [IW-1:0]  cand_s;
   logic [IW-1:0]  pick_s;
   logic           pick_vld_s;
   logic [LSIZE:0] beats_r;
   logic [LSIZE:0] cnt_r;
   logic [LSIZE:0] cnt_inc_s;
   logic           len_err_r;
   logic           aw_hs_s;
   logic           w_hs_s;
   logic           b_hs_s;
   logic           g_wlast_s;

   function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      return IW'((sum >= NUM) ? (sum - NUM) : sum);
   endfunction

   // Round-robin pick; scanning offsets downward lets the smallest offset from rr_ptr win.
   always_comb begin
      cand_s     = '0;
      pick_s     = '0;
      pick_vld_s = 1'b0;
      for (int i = NUM - 1; i >= 0; i--) begin
         cand_s     = wrap_add(rr_ptr_r, i);
         pick_vld_s = pick_vld_s | s.awvalid[cand_s];
         pick_s     = s.awvalid[cand_s] ? cand_s : pick_s;
      end
   end

   assign g_wlast_s = s.wlast[gidx_r];
   assign aw_hs_s   = (state_r == ST_AW) & m.awready[0];
   assign w_hs_s    = (state_r == ST_W) & s.wvalid[gidx_r] & m.wready[0];
   assign b_hs_s    = (state_r == ST_B) & s.bready[gidx_r] & m.bvalid[0];
   // Saturate so an overlong burst can never wrap back onto a matching count.
   assign cnt_inc_s = (&cnt_r) ? cnt_r : cnt_r + (LSIZE + 1)'(1'b1);

   // State register.
   always_ff @(posedge axi_aclk) begin
      if (axi_rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state_r;
      case (state_r)
         ST_IDLE: state_nxt = pick_vld_s ? ST_AW : ST_IDLE;
         ST_AW:   state_nxt = aw_hs_s ? ST_W : ST_AW;
         ST_W:    state_nxt = (w_hs_s && g_wlast_s) ? ST_B : ST_W;
         ST_B:    state_nxt = b_hs_s ? ST_IDLE : ST_B;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Grant, round-robin pointer, beat accounting and the sticky length error.
   always_ff @(posedge axi_aclk) begin
      if (axi_rst) begin
         grant_r   <= '0;
         gidx_r    <= '0;
         rr_ptr_r  <= '0;
         beats_r   <= '0;
         cnt_r     <= '0;
         len_err_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (pick_vld_s) begin
                  grant_r <= NUM'(1'b1) << pick_s;
                  gidx_r  <= pick_s;
               end
            end
            ST_AW: begin
               if (aw_hs_s) begin
                  beats_r <= {1'b0, s.awlen[int'(gidx_r)*LSIZE +: LSIZE]} + (LSIZE + 1)'(1'b1);
                  cnt_r   <= '0;
               end
            end
            ST_W: begin
               if (w_hs_s) begin
                  cnt_r <= cnt_inc_s;
                  // Error when wlast and "count reached awlen+1" disagree on this beat.
                  if (g_wlast_s != (cnt_inc_s == beats_r)) begin
                     len_err_r <= 1'b1;
                  end
               end
            end
            ST_B: begin
               if (b_hs_s) begin
                  rr_ptr_r <= wrap_add(gidx_r, 1);
                  grant_r  <= '0;
               end
            end
            default: begin
               grant_r <= '0;
            end
         endcase
      end
   end

   // Output steering between the granted master and the slave.
   always_comb begin
      m.awvalid = 1'b0;
      m.awaddr  = '0;
      m.awlen   = '0;
      m.awid    = '0;
      m.wvalid  = 1'b0;
      m.wdata   = '0;
      m.wlast   = 1'b0;
      m.bready  = 1'b0;
      s.awready = '0;
      s.wready  = '0;
      s.bvalid  = '0;
      s.bresp   = 2'b00;
      case (state_r)
         ST_AW: begin
            m.awvalid = 1'b1;
            m.awaddr  = s.awaddr[int'(gidx_r)*ASIZE +: ASIZE];
            m.awlen   = s.awlen[int'(gidx_r)*LSIZE +: LSIZE];
            m.awid    = s.awid[int'(gidx_r)*IDSIZE +: IDSIZE];
            s.awready = grant_r & {NUM{m.awready[0]}};
         end
         ST_W: begin
            m.wvalid = s.wvalid[gidx_r];
            m.wdata  = s.wdata[int'(gidx_r)*DSIZE +: DSIZE];
            m.wlast  = g_wlast_s;
            s.wready = grant_r & {NUM{m.wready[0]}};
         end
         ST_B: begin
            m.bready = s.bready[gidx_r];
            s.bvalid = grant_r & {NUM{m.bvalid[0]}};
            s.bresp  = m.bresp;
         end
         default: begin
            m.awvalid = 1'b0;
         end
      endcase
   end

   assign grant   = grant_r;
   assign busy    = (state_r != ST_IDLE);
   assign len_err = len_err_r;
endmodule
